// File: rtl/rx_freq_commit_sched_pkg.sv
// rtl/rx_freq_commit_sched_pkg.sv - shared constants and state encoding for the rx NCO frequency commit scheduler
package rx_freq_commit_sched_pkg;

    localparam int FREQ_BITS_DEF = 48;

    // Width of the high half of a phase increment; the low half is always one 32-bit register write.
    function automatic int h_bits(input int freq_bits);
        return freq_bits - 32;
    endfunction

    localparam int H_BITS_DEF = FREQ_BITS_DEF - 32;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } state_e;

endpackage

// File: rtl/rx_freq_commit_sched_if.sv
// rtl/rx_freq_commit_sched_if.sv - register-write staging inputs and config-bus commit outputs
interface rx_freq_commit_sched_if
    import rx_freq_commit_sched_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int CH_BITS   = 2,
    parameter int FREQ_BITS = FREQ_BITS_DEF
);
    logic                 wr_lo;
    logic                 wr_hi;
    logic [CH_BITS-1:0]   wr_chan;
    logic [31:0]          wr_data;
    logic                 sample_boundary;
    logic                 clr_ovr;
    logic                 cfg_we;
    logic [CH_BITS-1:0]   cfg_chan;
    logic [FREQ_BITS-1:0] cfg_freq;
    logic [NCH-1:0]       pending;
    logic                 busy;
    logic [NCH-1:0]       ovr_sticky;

    modport master (
        output wr_lo, wr_hi, wr_chan, wr_data, sample_boundary, clr_ovr,
        input  cfg_we, cfg_chan, cfg_freq, pending, busy, ovr_sticky
    );

    modport slave (
        input  wr_lo, wr_hi, wr_chan, wr_data, sample_boundary, clr_ovr,
        output cfg_we, cfg_chan, cfg_freq, pending, busy, ovr_sticky
    );
endinterface

// File: rtl/rx_freq_commit_sched_rr_pick.sv
// rtl/rx_freq_commit_sched_rr_pick.sv - rotating priority encoder: first set mask bit at or after start, with wrap
module rx_freq_commit_sched_rr_pick #(
    parameter int NCH     = 4,
    parameter int CH_BITS = 2
) (
    input  logic [NCH-1:0]     mask,
    input  logic [CH_BITS-1:0] start,
    output logic [CH_BITS-1:0] idx,
    output logic               valid
);
    logic [CH_BITS-1:0] cand;

    // Walk the mask from start upward; the first hit wins so later candidates are ignored.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = CH_BITS'((int'(start) + i) % NCH);
            if (!valid && mask[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/rx_freq_commit_sched.sv
// rtl/rx_freq_commit_sched.sv - stages split H/L NCO frequency writes and commits them round-robin in sample-aligned windows
module rx_freq_commit_sched
    import rx_freq_commit_sched_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int CH_BITS   = 2,
    parameter int FREQ_BITS = FREQ_BITS_DEF
) (
    input  logic                   adc_clk,
    input  logic                   reset_n,
    rx_freq_commit_sched_if.slave  bus
);
    localparam int H_BITS = h_bits(FREQ_BITS);

    state_e               state_q, state_d;
    logic [NCH-1:0]       snap_q, snap_d;
    logic [NCH-1:0]       pending_q, pending_d;
    logic [NCH-1:0]       ovr_q, ovr_d;
    logic [CH_BITS-1:0]   rr_ptr_q, rr_ptr_d;
    logic                 boundary_q, boundary_d;
    logic                 cfg_we_q, cfg_we_d;
    logic [CH_BITS-1:0]   cfg_chan_q, cfg_chan_d;
    logic [FREQ_BITS-1:0] cfg_freq_q, cfg_freq_d;
    logic                 busy_q, busy_d;
    logic [31:0]          lo_q [NCH];
    logic [31:0]          lo_d [NCH];
    logic [H_BITS-1:0]    hi_q [NCH];
    logic [H_BITS-1:0]    hi_d [NCH];

    logic [NCH-1:0]       pick_mask;
    logic [NCH-1:0]       pick_onehot;
    logic [CH_BITS-1:0]   pick_idx;
    logic                 pick_valid;
    logic                 do_commit;

    // IDLE picks straight from pending so the first word lands one cycle after the boundary;
    // inside a window only the snapshot is eligible.
    always_comb begin
        pick_mask   = (state_q == ST_IDLE) ? pending_q : snap_q;
        pick_onehot = NCH'(1) << pick_idx;
    end

    rx_freq_commit_sched_rr_pick #(
        .NCH     (NCH),
        .CH_BITS (CH_BITS)
    ) u_rr_pick (
        .mask  (pick_mask),
        .start (rr_ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Window sequencing, commit selection and staging; register writes are applied last so a
    // same-cycle wr_hi re-arms a channel that is being committed from its old staged value.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        pending_d  = pending_q;
        ovr_d      = bus.clr_ovr ? '0 : ovr_q;
        rr_ptr_d   = rr_ptr_q;
        boundary_d = boundary_q;
        cfg_we_d   = 1'b0;
        cfg_chan_d = cfg_chan_q;
        cfg_freq_d = cfg_freq_q;
        busy_d     = busy_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        do_commit  = 1'b0;

        if (state_q == ST_IDLE) begin
            if (bus.sample_boundary || boundary_q) begin
                boundary_d = 1'b0;
                do_commit  = pick_valid;
            end
        end else begin
            if (bus.sample_boundary) begin
                boundary_d = 1'b1;
            end
            do_commit = pick_valid;
        end

        if (do_commit) begin
            state_d    = ST_COMMIT;
            busy_d     = 1'b1;
            cfg_we_d   = 1'b1;
            cfg_chan_d = pick_idx;
            cfg_freq_d = {hi_q[pick_idx], lo_q[pick_idx]};
            snap_d     = pick_mask & ~pick_onehot;
            pending_d  = pending_q & ~pick_onehot;
            rr_ptr_d   = (pick_idx == CH_BITS'(NCH - 1)) ? '0 : pick_idx + 1'b1;
        end else if (state_q == ST_COMMIT) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            snap_d  = '0;
        end

        if (bus.wr_lo) begin
            lo_d[bus.wr_chan] = bus.wr_data;
        end
        if (bus.wr_hi) begin
            hi_d[bus.wr_chan] = bus.wr_data[H_BITS-1:0];
            if (pending_q[bus.wr_chan]) begin
                ovr_d[bus.wr_chan] = 1'b1;
            end
            pending_d[bus.wr_chan] = 1'b1;
        end
    end

    // State and output registers; reset drops cfg_we at once, aborting any open window.
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            snap_q     <= '0;
            pending_q  <= '0;
            ovr_q      <= '0;
            rr_ptr_q   <= '0;
            boundary_q <= 1'b0;
            cfg_we_q   <= 1'b0;
            cfg_chan_q <= '0;
            cfg_freq_q <= '0;
            busy_q     <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                lo_q[i] <= '0;
                hi_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            pending_q  <= pending_d;
            ovr_q      <= ovr_d;
            rr_ptr_q   <= rr_ptr_d;
            boundary_q <= boundary_d;
            cfg_we_q   <= cfg_we_d;
            cfg_chan_q <= cfg_chan_d;
            cfg_freq_q <= cfg_freq_d;
            busy_q     <= busy_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
        end
    end

    assign bus.cfg_we     = cfg_we_q;
    assign bus.cfg_chan   = cfg_chan_q;
    assign bus.cfg_freq   = cfg_freq_q;
    assign bus.pending    = pending_q;
    assign bus.busy       = busy_q;
    assign bus.ovr_sticky = ovr_q;
endmodule

// File: tb/tb_rx_freq_commit_sched.sv
// tb/tb_rx_freq_commit_sched.sv - directed self-checking bench for rx_freq_commit_sched
module tb_rx_freq_commit_sched;
    localparam int NCH       = 4;
    localparam int CH_BITS   = 2;
    localparam int FREQ_BITS = 48;
    localparam int NVEC      = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rx_freq_commit_sched_if #(.NCH(NCH), .CH_BITS(CH_BITS), .FREQ_BITS(FREQ_BITS)) bus ();

    rx_freq_commit_sched #(.NCH(NCH), .CH_BITS(CH_BITS), .FREQ_BITS(FREQ_BITS)) dut (
        .adc_clk (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic        lo;
        logic        hi;
        logic [1:0]  ch;
        logic [31:0] data;
        logic        bnd;
        logic        clr;
        logic        we;
        logic [1:0]  chan;
        logic [47:0] freq;
        logic [3:0]  pend;
        logic        busy;
        logic [3:0]  ovr;
    } vec_t;

    vec_t vt [NVEC];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] fboth(input logic [31:0] d);
        return {d[15:0], d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_lo           = 1'b0;
        bus.wr_hi           = 1'b0;
        bus.wr_chan         = '0;
        bus.wr_data         = '0;
        bus.sample_boundary = 1'b0;
        bus.clr_ovr         = 1'b0;
    endtask

    task automatic wr_both(input logic [1:0] ch, input logic [31:0] d);
        bus.wr_lo   = 1'b1;
        bus.wr_hi   = 1'b1;
        bus.wr_chan = ch;
        bus.wr_data = d;
        tick();
        bus.wr_lo   = 1'b0;
        bus.wr_hi   = 1'b0;
    endtask

    task automatic bnd();
        bus.sample_boundary = 1'b1;
        tick();
        bus.sample_boundary = 1'b0;
    endtask

    task automatic chk_commit(input string tag, input logic [1:0] ch, input logic [47:0] fr);
        check({tag, "_we"},   bus.cfg_we,   1);
        check({tag, "_busy"}, bus.busy,     1);
        check({tag, "_chan"}, bus.cfg_chan, ch);
        check({tag, "_freq"}, bus.cfg_freq, fr);
    endtask

    task automatic chk_quiet(input string tag);
        check({tag, "_we"},   bus.cfg_we, 0);
        check({tag, "_busy"}, bus.busy,   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        lo    hi    ch    data           bnd   clr   we    chan  freq                pend   busy  ovr
        vt[0]  = '{1'b1, 1'b0, 2'd2, 32'h89AB_CDEF, 1'b0, 1'b0, 1'b0, 2'd0, 48'h0,              4'h0, 1'b0, 4'h0};
        vt[1]  = '{1'b0, 1'b1, 2'd2, 32'h0000_0123, 1'b0, 1'b0, 1'b0, 2'd0, 48'h0,              4'h4, 1'b0, 4'h0};
        vt[2]  = '{1'b0, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b0, 2'd0, 48'h0,              4'h4, 1'b0, 4'h0};
        vt[3]  = '{1'b0, 1'b0, 2'd0, 32'h0,         1'b1, 1'b0, 1'b1, 2'd2, 48'h0123_89AB_CDEF, 4'h0, 1'b1, 4'h0};
        vt[4]  = '{1'b0, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b0, 2'd2, 48'h0123_89AB_CDEF, 4'h0, 1'b0, 4'h0};
        vt[5]  = '{1'b1, 1'b0, 2'd1, 32'h1111_2222, 1'b0, 1'b0, 1'b0, 2'd2, 48'h0123_89AB_CDEF, 4'h0, 1'b0, 4'h0};
        vt[6]  = '{1'b1, 1'b0, 2'd3, 32'h3333_4444, 1'b0, 1'b0, 1'b0, 2'd2, 48'h0123_89AB_CDEF, 4'h0, 1'b0, 4'h0};
        vt[7]  = '{1'b0, 1'b0, 2'd0, 32'h0,         1'b1, 1'b0, 1'b0, 2'd2, 48'h0123_89AB_CDEF, 4'h0, 1'b0, 4'h0};
        vt[8]  = '{1'b0, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b0, 2'd2, 48'h0123_89AB_CDEF, 4'h0, 1'b0, 4'h0};
        vt[9]  = '{1'b0, 1'b1, 2'd1, 32'h0000_AAAA, 1'b0, 1'b0, 1'b0, 2'd2, 48'h0123_89AB_CDEF, 4'h2, 1'b0, 4'h0};
        vt[10] = '{1'b0, 1'b1, 2'd1, 32'h0000_BBBB, 1'b0, 1'b0, 1'b0, 2'd2, 48'h0123_89AB_CDEF, 4'h2, 1'b0, 4'h2};
        vt[11] = '{1'b0, 1'b0, 2'd0, 32'h0,         1'b1, 1'b0, 1'b1, 2'd1, 48'hBBBB_1111_2222, 4'h0, 1'b1, 4'h2};
        vt[12] = '{1'b0, 1'b0, 2'd0, 32'h0,         1'b0, 1'b1, 1'b0, 2'd1, 48'hBBBB_1111_2222, 4'h0, 1'b0, 4'h0};
        vt[13] = '{1'b1, 1'b1, 2'd0, 32'h5555_CCCC, 1'b0, 1'b0, 1'b0, 2'd1, 48'hBBBB_1111_2222, 4'h1, 1'b0, 4'h0};
        vt[14] = '{1'b0, 1'b0, 2'd0, 32'h0,         1'b1, 1'b1, 1'b1, 2'd0, 48'hCCCC_5555_CCCC, 4'h0, 1'b1, 4'h0};
        vt[15] = '{1'b0, 1'b0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b0, 2'd0, 48'hCCCC_5555_CCCC, 4'h0, 1'b0, 4'h0};
        vt[16] = '{1'b0, 1'b1, 2'd3, 32'h0000_1111, 1'b0, 1'b0, 1'b0, 2'd0, 48'hCCCC_5555_CCCC, 4'h8, 1'b0, 4'h0};
        vt[17] = '{1'b0, 1'b1, 2'd3, 32'h0000_2222, 1'b0, 1'b1, 1'b0, 2'd0, 48'hCCCC_5555_CCCC, 4'h8, 1'b0, 4'h8};
        vt[18] = '{1'b0, 1'b0, 2'd0, 32'h0,         1'b1, 1'b0, 1'b1, 2'd3, 48'h2222_3333_4444, 4'h0, 1'b1, 4'h8};
        vt[19] = '{1'b0, 1'b0, 2'd0, 32'h0,         1'b0, 1'b1, 1'b0, 2'd3, 48'h2222_3333_4444, 4'h0, 1'b0, 4'h0};

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_we",      bus.cfg_we,     0);
        check("rst_chan",    bus.cfg_chan,   0);
        check("rst_freq",    bus.cfg_freq,   0);
        check("rst_pending", bus.pending,    0);
        check("rst_busy",    bus.busy,       0);
        check("rst_ovr",     bus.ovr_sticky, 0);

        for (int i = 0; i < NVEC; i++) begin
            bus.wr_lo           = vt[i].lo;
            bus.wr_hi           = vt[i].hi;
            bus.wr_chan         = vt[i].ch;
            bus.wr_data         = vt[i].data;
            bus.sample_boundary = vt[i].bnd;
            bus.clr_ovr         = vt[i].clr;
            tick();
            idle_inputs();
            check($sformatf("vec%0d_we", i),   bus.cfg_we,     vt[i].we);
            check($sformatf("vec%0d_chan", i), bus.cfg_chan,   vt[i].chan);
            check($sformatf("vec%0d_freq", i), bus.cfg_freq,   vt[i].freq);
            check($sformatf("vec%0d_pend", i), bus.pending,    vt[i].pend);
            check($sformatf("vec%0d_busy", i), bus.busy,       vt[i].busy);
            check($sformatf("vec%0d_ovr", i),  bus.ovr_sticky, vt[i].ovr);
        end

        // Round-robin: move the pointer to 1 with a lone ch0 commit, then arm 0,1,3.
        wr_both(2'd0, 32'hA0A0_1234);
        bnd();
        chk_commit("rr_pre", 2'd0, fboth(32'hA0A0_1234));
        tick();
        chk_quiet("rr_pre_end");
        wr_both(2'd0, 32'h1000_0AAA);
        wr_both(2'd1, 32'h2000_0BBB);
        wr_both(2'd3, 32'h3000_0DDD);
        check("rr_armed", bus.pending, 4'b1011);
        bnd();
        chk_commit("rr_w1", 2'd1, fboth(32'h2000_0BBB));
        tick();
        chk_commit("rr_w2", 2'd3, fboth(32'h3000_0DDD));
        tick();
        chk_commit("rr_w3", 2'd0, fboth(32'h1000_0AAA));
        tick();
        chk_quiet("rr_end");
        check("rr_pend_clear", bus.pending, 0);
        wr_both(2'd0, 32'h4000_0EEE);
        wr_both(2'd2, 32'h5000_0FFF);
        bnd();
        chk_commit("rr_ptr_a", 2'd2, fboth(32'h5000_0FFF));
        tick();
        chk_commit("rr_ptr_b", 2'd0, fboth(32'h4000_0EEE));
        tick();
        chk_quiet("rr_ptr_end");

        // wr_hi on ch1 in the cycle its commit is decided: old value out, channel stays armed.
        wr_both(2'd1, 32'h6000_1111);
        bus.sample_boundary = 1'b1;
        bus.wr_hi           = 1'b1;
        bus.wr_chan         = 2'd1;
        bus.wr_data         = 32'h0000_7777;
        tick();
        idle_inputs();
        chk_commit("conf_old", 2'd1, fboth(32'h6000_1111));
        check("conf_pend", bus.pending,    4'b0010);
        check("conf_ovr",  bus.ovr_sticky, 4'b0010);
        tick();
        chk_quiet("conf_end");
        check("conf_pend_hold", bus.pending, 4'b0010);
        bus.clr_ovr = 1'b1;
        tick();
        bus.clr_ovr = 1'b0;
        check("conf_ovr_clr", bus.ovr_sticky, 0);
        bnd();
        chk_commit("conf_new", 2'd1, {16'h7777, 32'h6000_1111});
        tick();
        chk_quiet("conf_new_end");
        check("conf_pend_done", bus.pending, 0);

        // Boundaries arriving inside a window: the first is held, the second is dropped.
        wr_both(2'd0, 32'h1111_000A);
        wr_both(2'd1, 32'h2222_000B);
        wr_both(2'd2, 32'h3333_000C);
        wr_both(2'd3, 32'h4444_000D);
        bnd();
        chk_commit("bw_w1", 2'd2, fboth(32'h3333_000C));
        wr_both(2'd2, 32'h5555_00EE);
        chk_commit("bw_w2", 2'd3, fboth(32'h4444_000D));
        check("bw_pend_w2", bus.pending, 4'b0111);
        bnd();
        chk_commit("bw_w3", 2'd0, fboth(32'h1111_000A));
        bnd();
        chk_commit("bw_w4", 2'd1, fboth(32'h2222_000B));
        check("bw_pend_w4", bus.pending, 4'b0100);
        tick();
        chk_quiet("bw_gap");
        tick();
        chk_commit("bw_second", 2'd2, fboth(32'h5555_00EE));
        wr_both(2'd1, 32'h6666_00FF);
        chk_quiet("bw_second_end");
        check("bw_pend_late", bus.pending, 4'b0010);
        tick();
        chk_quiet("bw_dropped_a");
        tick();
        chk_quiet("bw_dropped_b");
        check("bw_pend_wait", bus.pending,    4'b0010);
        check("bw_ovr",       bus.ovr_sticky, 0);
        bnd();
        chk_commit("bw_late", 2'd1, fboth(32'h6666_00FF));
        tick();
        chk_quiet("bw_late_end");

        // Reset asserted during the second of three commits.
        wr_both(2'd0, 32'h0AAA_0001);
        wr_both(2'd1, 32'h0BBB_0002);
        wr_both(2'd3, 32'h0DDD_0003);
        bnd();
        chk_commit("rstw_w1", 2'd3, fboth(32'h0DDD_0003));
        tick();
        chk_commit("rstw_w2", 2'd0, fboth(32'h0AAA_0001));
        #2;
        rst_n = 1'b0;
        #1;
        check("rstw_we_async",   bus.cfg_we, 0);
        check("rstw_busy_async", bus.busy,   0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rstw_chan",    bus.cfg_chan,   0);
        check("rstw_freq",    bus.cfg_freq,   0);
        check("rstw_pending", bus.pending,    0);
        check("rstw_ovr",     bus.ovr_sticky, 0);
        chk_quiet("rstw_idle");
        bnd();
        chk_quiet("rstw_bnd_a");
        tick();
        chk_quiet("rstw_bnd_b");
        check("rstw_pend_after", bus.pending, 0);
        bus.wr_hi   = 1'b1;
        bus.wr_chan = 2'd0;
        bus.wr_data = 32'h0000_9ABC;
        tick();
        idle_inputs();
        bnd();
        chk_commit("rstw_new", 2'd0, 48'h9ABC_0000_0000);
        tick();
        chk_quiet("rstw_new_end");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
